// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } fc_state_e;

  // Neuron output width: full product plus accumulation growth over the fan-in.
  function automatic int unsigned zw_f(input int unsigned width, input int unsigned in_n);
    return width * 2 + $clog2(in_n);
  endfunction

  // Index/counter width with a floor of one bit for degenerate sizes.
  function automatic int unsigned idxw_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_result_buf.sv
// Capture bank for all neuron outputs plus the serial valid/ready result stream.
module fc_result_buf
  import fc_pkg::*;
#(
  parameter  int unsigned NEURONS = 32,
  parameter  int unsigned ZW      = 23,
  localparam int unsigned IDXW    = idxw_f(NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture_i,
  input  logic [NEURONS-1:0][ZW-1:0]   z_i,
  input  logic                         out_ready_i,
  output logic                         out_valid_o,
  output logic [ZW-1:0]                out_data_o,
  output logic [IDXW-1:0]              out_idx_o,
  output logic                         out_last_o
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NEURONS - 1);

  logic [NEURONS-1:0][ZW-1:0] zcap_q, zcap_d;
  logic                       valid_q, valid_d;
  logic [ZW-1:0]              data_q, data_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic                       last_q, last_d;
  logic [IDXW-1:0]            idx_nxt;

  assign idx_nxt = idx_q + IDXW'(1);

  // Output beat registers are preloaded with the next entry so data never comes from a live mux.
  always_comb begin
    zcap_d  = zcap_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (capture_i) begin
      zcap_d  = z_i;
      valid_d = 1'b1;
      data_d  = z_i[0];
      idx_d   = '0;
      last_d  = (NEURONS == 1);
    end else if (valid_q && out_ready_i) begin
      if (last_q) begin
        valid_d = 1'b0;
        idx_d   = '0;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_nxt;
        data_d = zcap_q[idx_nxt];
        last_d = (idx_nxt == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zcap_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      zcap_q  <= zcap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/fc_layer_seq.sv
// Frame sequencer for one fully-connected layer: load activations, let the
// combinational neurons settle, capture their outputs, then stream results out.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned IN      = 128,
  parameter  int unsigned NEURONS = 32,
  parameter  int unsigned SETTLE  = 3,
  localparam int unsigned ZW      = zw_f(WIDTH, IN),
  localparam int unsigned IDXW    = idxw_f(NEURONS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic [IN-1:0][WIDTH-1:0]       x_bus,
  input  logic [NEURONS-1:0][ZW-1:0]     z_bus,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ZW-1:0]                  out_data,
  output logic [IDXW-1:0]                out_idx,
  output logic                           out_last,
  output logic                           busy,
  output logic                           frame_err
);

  localparam int unsigned CNTW  = idxw_f(IN);
  localparam int unsigned WAITW = idxw_f(SETTLE);
  localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(IN - 1);
  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(SETTLE - 1);

  fc_state_e                state_q, state_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [WAITW-1:0]         wait_q, wait_d;
  logic [IN-1:0][WIDTH-1:0] x_q, x_d;
  logic                     err_q, err_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;
  logic                     capture_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    x_d       = x_q;
    err_d     = err_q;
    capture_c = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          x_d[cnt_q] = in_data;
          // in_last is only audited; the frame length is fixed by the counter.
          if (in_last != (cnt_q == CNT_LAST)) err_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            wait_d  = '0;
            state_d = ST_SETTLE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (wait_q == WAIT_LAST) begin
          capture_c = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          wait_d = wait_q + WAITW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      wait_q     <= '0;
      x_q        <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      x_q        <= x_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  fc_result_buf #(
    .NEURONS (NEURONS),
    .ZW      (ZW)
  ) u_result_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_i   (capture_c),
    .z_i         (z_bus),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last)
  );

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign frame_err = err_q;
  assign x_bus     = x_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with a behavioural constant-weight neuron model on z_bus.
module tb_fc_layer_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned IN     = 128;
  localparam int unsigned N      = 32;
  localparam int unsigned SETTLE = 3;
  localparam int unsigned ZW     = 23;
  localparam int unsigned IDXW   = 5;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data = '0;
  logic                       in_last = 1'b0;
  logic [IN-1:0][WIDTH-1:0]   x_bus;
  logic [N-1:0][ZW-1:0]       z_bus;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [ZW-1:0]              out_data;
  logic [IDXW-1:0]            out_idx;
  logic                       out_last;
  logic                       busy;
  logic                       frame_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_z [N];
  logic z_force = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .x_bus     (x_bus),
    .z_bus     (z_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .frame_err (frame_err)
  );

  function automatic int w_of(input int n, input int i);
    return ((n * 7 + i * 3) % 13) + 1;
  endfunction

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(3 * i + 7);
      2:       return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic void compute_exp(input int mode);
    for (int n = 0; n < N; n++) begin
      int s;
      s = 0;
      for (int i = 0; i < IN; i++) s += int'(pat(mode, i)) * w_of(n, i);
      exp_z[n] = s;
    end
  endfunction

  // Neuron layer stand-in; z_force corrupts it to prove results come from the capture bank.
  always_comb begin
    int unsigned acc;
    for (int n = 0; n < N; n++) begin
      acc = 0;
      for (int i = 0; i < IN; i++) acc += 32'(x_bus[i]) * 32'(w_of(n, i));
      z_bus[n] = z_force ? ZW'(n * 1000 + 12345) : ZW'(acc);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; z_force = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input int mode, input int pct, input int last_at,
                      output int first_cyc, output int last_cyc);
    int  i;
    int  guard;
    logic acc;
    i = 0; guard = 0; first_cyc = -1; last_cyc = -1;
    while (i < IN && guard < 5000) begin
      guard++;
      in_valid = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      in_data  = pat(mode, i);
      in_last  = (i == last_at);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (i == 0) first_cyc = cyc;
        last_cyc = cyc;
        i++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (i < IN) begin
      errors++;
      $display("FAIL load_timeout accepted=%0d required=%0d", i, IN);
    end
  endtask

  task automatic drain(input int pct, input int stop_at, input int exp_lat);
    int   k, lat, guard;
    logic rdy, stalled;
    logic [ZW-1:0]   sd;
    logic [IDXW-1:0] si;
    logic            sl;
    k = 0; lat = 0; guard = 0; stalled = 1'b0; sd = '0; si = '0; sl = 1'b0;
    while (k < stop_at && guard < 2000) begin
      guard++;
      if (!out_valid && k == 0) lat++;
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_in_drain got=%b want=0 k=%0d", in_ready, k);
        end
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== sd || out_idx !== si || out_last !== sl) begin
          errors++;
          $display("FAIL stall_stable got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                   out_valid, out_data, out_idx, out_last, sd, si, sl);
        end
      end
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      out_ready = rdy;
      if (out_valid && rdy) begin
        checks++;
        if (out_idx !== IDXW'(k) || out_data !== ZW'(exp_z[k]) || out_last !== (k == N - 1)) begin
          errors++;
          $display("FAIL result_beat got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                   out_idx, out_data, out_last, k, exp_z[k], (k == N - 1));
        end
        k++;
      end
      stalled = out_valid && !rdy;
      sd = out_data; si = out_idx; sl = out_last;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (k < stop_at) begin
      errors++;
      $display("FAIL drain_timeout got=%0d beats want=%0d", k, stop_at);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL first_valid_latency got=%0d want=%0d", lat, exp_lat);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0 || frame_err !== 1'b0 || x_bus !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b ov=%b idx=%0d last=%b busy=%b err=%b xnz=%b want 1 0 0 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, busy, frame_err, |x_bus);
    end
  endtask

  task automatic test_single_frame();
    int f, l;
    compute_exp(0);
    load(0, 100, IN - 1, f, l);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL settle_flags got busy=%b rdy=%b err=%b want 1 0 0", busy, in_ready, frame_err);
    end
    drain(100, N, SETTLE);
    checks++;
    if (frame_err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_drain got err=%b rdy=%b busy=%b ov=%b want 0 1 0 0",
               frame_err, in_ready, busy, out_valid);
    end
  endtask

  task automatic test_random_stall();
    int f, l;
    compute_exp(0);
    load(0, 50, IN - 1, f, l);
    drain(30, N, SETTLE);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL random_frame_err got=%b want=0", frame_err);
    end
  endtask

  task automatic test_early_last();
    int f, l;
    compute_exp(1);
    load(1, 100, 60, f, l);
    checks++;
    if (frame_err !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL early_last got err=%b rdy=%b want 1 0", frame_err, in_ready);
    end
    drain(100, N, SETTLE);
    checks++;
    if (frame_err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got err=%b rdy=%b want 1 1", frame_err, in_ready);
    end
  endtask

  task automatic test_capture_hold();
    int f, l;
    logic [IN-1:0][WIDTH-1:0] xe;
    do_reset();
    compute_exp(1);
    for (int i = 0; i < IN; i++) xe[i] = pat(1, i);
    load(1, 100, IN - 1, f, l);
    for (int c = 0; c < SETTLE; c++) begin
      checks++;
      if (x_bus !== xe) begin
        errors++;
        $display("FAIL x_frozen cycle=%0d got x0=%0d x127=%0d want x0=%0d x127=%0d",
                 c, x_bus[0], x_bus[IN-1], xe[0], xe[IN-1]);
      end
      in_valid = 1'b1; in_data = 8'hAA;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_timing got ov=%b want=1", out_valid);
    end
    z_force = 1'b1;
    drain(100, N, 0);
    z_force = 1'b0;
    checks++;
    if (x_bus !== xe || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL x_held_after_drain got match=%b err=%b want 1 0", (x_bus === xe), frame_err);
    end
  endtask

  task automatic test_reset_in_drain();
    int f, l;
    compute_exp(0);
    load(0, 100, 10, f, l);
    drain(100, 10, SETTLE);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== IDXW'(10) || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got ov=%b idx=%0d err=%b want 1 10 1", out_valid, out_idx, frame_err);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== '0 || frame_err !== 1'b0 ||
        busy !== 1'b0 || x_bus !== '0) begin
      errors++;
      $display("FAIL reset_in_drain got ov=%b rdy=%b idx=%0d err=%b busy=%b xnz=%b want 0 1 0 0 0 0",
               out_valid, in_ready, out_idx, frame_err, busy, |x_bus);
    end
  endtask

  task automatic test_back_to_back();
    int f1, l1, f2, l2;
    compute_exp(2);
    load(2, 100, IN - 1, f1, l1);
    drain(100, N, SETTLE);
    compute_exp(3);
    load(3, 100, IN - 1, f2, l2);
    drain(100, N, SETTLE);
    checks++;
    if (l1 - f1 != IN - 1) begin
      errors++;
      $display("FAIL load_gapless got=%0d want=%0d", l1 - f1, IN - 1);
    end
    checks++;
    if (f2 - f1 != IN + SETTLE + N) begin
      errors++;
      $display("FAIL frame_period got=%0d want=%0d", f2 - f1, IN + SETTLE + N);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frame_err got=%b want=0", frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_stall();
    test_early_last();
    test_capture_hold();
    test_reset_in_drain();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
